phase_fifo_reader: RTL and testbench

- Read-side consumer for the phase-tag FIFO. Runs in the FIFO read clock domain.
- Drives the FIFO read enable and absorbs the FIFO's one-cycle read latency.
- Unpacks each 8-bit word {start_count[2:0], phase_tag[4:0]} and presents it on a valid/ready stream through a 2-entry skid buffer.
- Checks start_count continuity to detect dropped words, whether lost to write-side full suppression or upstream gaps, and keeps word and gap statistics.

---
 rtl/phase_fifo_reader.sv | 131 +++++++++++++
 tb/tb_phase_fifo_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_fifo_reader.sv
// Read-side consumer for the phase-tag FIFO: issues reads, absorbs the one-cycle
// read latency, unpacks words into a 2-entry skid buffer and tracks start_count continuity.
module phase_fifo_reader #(
  parameter int TAG_W     = 5,
  parameter int CNT_W     = 3,
  parameter int STAT_W    = 16,
  parameter int SEQ_CHECK = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [TAG_W+CNT_W-1:0] fifo_q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_W-1:0]       out_phase_tag,
  output logic [CNT_W-1:0]       out_start_count,
  output logic                   out_seq_err,
  input  logic                   clear_stats,
  output logic [STAT_W-1:0]      word_count,
  output logic [STAT_W-1:0]      gap_count
);

  // Stream handshake: a word transfers on any rising edge where out_valid and
  // out_ready are both high; out_* hold steady while out_valid=1 and out_ready=0.

  logic             inflight;
  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic [CNT_W-1:0] s1_cnt;
  logic             s1_err;
  logic             ref_valid;
  logic [CNT_W-1:0] ref_cnt;

  logic             pop;
  logic [1:0]       occ;
  logic [TAG_W-1:0] cap_tag;
  logic [CNT_W-1:0] cap_cnt;
  logic             cap_err;

  assign pop = out_valid & out_ready;
  assign occ = {1'b0, out_valid} + {1'b0, s1_valid};

  // Entries held plus the word in flight, minus the one leaving now, must leave room.
  assign fifo_rd_en = ~fifo_empty & ~rst &
                      (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign cap_tag = fifo_q[TAG_W-1:0];
  assign cap_cnt = fifo_q[TAG_W+CNT_W-1:TAG_W];
  assign cap_err = (SEQ_CHECK != 0) && ref_valid &&
                   (cap_cnt != CNT_W'(ref_cnt + CNT_W'(1)));

  // Skid buffer: the head entry drives out_* directly, s1 holds the overflow word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight        <= 1'b0;
      out_valid       <= 1'b0;
      out_phase_tag   <= '0;
      out_start_count <= '0;
      out_seq_err     <= 1'b0;
      s1_valid        <= 1'b0;
      s1_tag          <= '0;
      s1_cnt          <= '0;
      s1_err          <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      case ({inflight, pop})
        2'b11: begin
          if (s1_valid) begin
            out_phase_tag   <= s1_tag;
            out_start_count <= s1_cnt;
            out_seq_err     <= s1_err;
            s1_tag          <= cap_tag;
            s1_cnt          <= cap_cnt;
            s1_err          <= cap_err;
          end else begin
            out_phase_tag   <= cap_tag;
            out_start_count <= cap_cnt;
            out_seq_err     <= cap_err;
          end
        end
        2'b01: begin
          if (s1_valid) begin
            out_phase_tag   <= s1_tag;
            out_start_count <= s1_cnt;
            out_seq_err     <= s1_err;
            s1_valid        <= 1'b0;
          end else begin
            out_valid <= 1'b0;
          end
        end
        2'b10: begin
          if (!out_valid) begin
            out_phase_tag   <= cap_tag;
            out_start_count <= cap_cnt;
            out_seq_err     <= cap_err;
            out_valid       <= 1'b1;
          end else begin
            s1_tag   <= cap_tag;
            s1_cnt   <= cap_cnt;
            s1_err   <= cap_err;
            s1_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A capture coinciding with clear_stats is neither counted nor used as reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
      gap_count  <= '0;
      ref_valid  <= 1'b0;
      ref_cnt    <= '0;
    end else if (clear_stats) begin
      word_count <= '0;
      gap_count  <= '0;
      ref_valid  <= 1'b0;
    end else if (inflight) begin
      ref_valid <= 1'b1;
      ref_cnt   <= cap_cnt;
      if (word_count != {STAT_W{1'b1}})
        word_count <= word_count + STAT_W'(1);
      if (cap_err && (gap_count != {STAT_W{1'b1}}))
        gap_count <= gap_count + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_fifo_reader.sv
// Directed bench for phase_fifo_reader: behavioural FIFO with one-cycle read latency,
// scoreboard of expected output words, and a second instance with narrow, unchecked stats.
module tb_phase_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       out_ready;
  logic       clear_stats;
  logic       force_empty;
  logic       fifo_empty;
  logic [7:0] fifo_q;

  logic        fifo_rd_en, out_valid, out_seq_err;
  logic [4:0]  out_phase_tag;
  logic [2:0]  out_start_count;
  logic [15:0] word_count, gap_count;

  logic        fifo_rd_en_s, out_valid_s, out_seq_err_s;
  logic [4:0]  out_phase_tag_s;
  logic [2:0]  out_start_count_s;
  logic [3:0]  word_count_s, gap_count_s;

  logic [7:0] mem[$];
  logic [8:0] exp_q[$];
  int push_total = 0;
  int pop_total  = 0;
  int rd_cnt     = 0;
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  phase_fifo_reader dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_q(fifo_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_phase_tag(out_phase_tag), .out_start_count(out_start_count),
    .out_seq_err(out_seq_err), .clear_stats(clear_stats),
    .word_count(word_count), .gap_count(gap_count)
  );

  phase_fifo_reader #(.STAT_W(4), .SEQ_CHECK(0)) dut_s (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en_s),
    .fifo_q(fifo_q), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_phase_tag(out_phase_tag_s), .out_start_count(out_start_count_s),
    .out_seq_err(out_seq_err_s), .clear_stats(clear_stats),
    .word_count(word_count_s), .gap_count(gap_count_s)
  );

  // Behavioural FIFO: Q is valid the cycle after an accepted read.
  assign fifo_empty = force_empty | (push_total == pop_total);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_q    <= mem[pop_total];
      pop_total <= pop_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [2:0] cnt, input logic [4:0] tag, input logic err);
    mem.push_back({cnt, tag});
    push_total++;
    exp_q.push_back({err, cnt, tag});
  endtask

  // One clock: sample read requests and accepted words at negedge, then move past posedge.
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    if (fifo_rd_en) begin
      rd_cnt++;
      check("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
    end
    if (out_valid && out_ready) begin
      tests_run++;
      assert (exp_q.size() != 0) else begin
        tests_failed++;
        $error("FAIL unexpected_word: got %0h expected none",
               {out_seq_err, out_start_count, out_phase_tag});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("word", {23'd0, out_seq_err, out_start_count, out_phase_tag}, {23'd0, e});
        check("word_s", {24'd0, out_start_count_s, out_phase_tag_s}, {24'd0, e[7:0]});
        check("valid_s", {31'd0, out_valid_s}, 32'd1);
        check("seq_err_s", {31'd0, out_seq_err_s}, 32'd0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    tests_run++;
    assert (n < 200) else begin
      tests_failed++;
      $error("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int base;
    rst = 1'b1; out_ready = 1'b1; force_empty = 1'b0; clear_stats = 1'b0;

    // Reset values with three words preloaded
    push_word(3'd1, 5'd0, 1'b0);
    push_word(3'd2, 5'd0, 1'b0);
    push_word(3'd3, 5'd0, 1'b0);
    step(); step();
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 0);
    check("rst_word_count", {16'd0, word_count}, 0);
    check("rst_gap_count", {16'd0, gap_count}, 0);
    check("rst_out", {23'd0, out_seq_err, out_start_count, out_phase_tag}, 0);

    // Back-to-back reads, two-cycle latency to out_valid
    rst = 1'b0;
    #1;
    check("t1_rd_c0", {31'd0, fifo_rd_en}, 1);
    check("t1_valid_c0", {31'd0, out_valid}, 0);
    step();
    check("t1_rd_c1", {31'd0, fifo_rd_en}, 1);
    check("t1_valid_c1", {31'd0, out_valid}, 0);
    step();
    check("t1_rd_c2", {31'd0, fifo_rd_en}, 1);
    check("t1_valid_c2", {31'd0, out_valid}, 1);
    step();
    check("t1_rd_c3", {31'd0, fifo_rd_en}, 0);
    drain("t1");
    check("t1_word_count", {16'd0, word_count}, 3);
    check("t1_gap_count", {16'd0, gap_count}, 0);

    // Legal 7->0 wrap, then a skipped count
    push_word(3'd4, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd5, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd6, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd7, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd0, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd1, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd2, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd3, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd5, 5'($urandom_range(0, 31)), 1'b1);
    drain("t2");
    check("t2_word_count", {16'd0, word_count}, 12);
    check("t2_gap_count", {16'd0, gap_count}, 1);

    // Backpressure: only two reads, head held stable
    out_ready = 1'b0;
    base = rd_cnt;
    push_word(3'd6, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd7, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd0, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd1, 5'($urandom_range(0, 31)), 1'b0);
    repeat (3) step();
    check("t3_head_a", {27'd0, out_phase_tag}, {27'd0, exp_q[0][4:0]});
    repeat (6) step();
    check("t3_reads", rd_cnt - base, 2);
    check("t3_valid", {31'd0, out_valid}, 1);
    check("t3_head_b", {27'd0, out_phase_tag}, {27'd0, exp_q[0][4:0]});
    check("t3_head_cnt", {29'd0, out_start_count}, 6);
    out_ready = 1'b1;
    drain("t3");
    check("t3_word_count", {16'd0, word_count}, 16);

    // Empty held: no reads; one-cycle non-empty window: exactly one read
    force_empty = 1'b1;
    base = rd_cnt;
    push_word(3'd2, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd3, 5'($urandom_range(0, 31)), 1'b0);
    repeat (8) step();
    check("t4_no_reads", rd_cnt - base, 0);
    check("t4_no_valid", {31'd0, out_valid}, 0);
    force_empty = 1'b0;
    step();
    force_empty = 1'b1;
    repeat (5) step();
    check("t4_one_read", rd_cnt - base, 1);
    check("t4_pending", exp_q.size(), 1);
    check("t4_word_count", {16'd0, word_count}, 17);
    force_empty = 1'b0;
    drain("t4");
    check("t4_word_count_b", {16'd0, word_count}, 18);

    // clear_stats coinciding with the capture of a gap word
    force_empty = 1'b1;
    push_word(3'd7, 5'($urandom_range(0, 31)), 1'b1);
    force_empty = 1'b0;
    step();
    force_empty = 1'b1;
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("t5_word_count_clr", {16'd0, word_count}, 0);
    check("t5_gap_count_clr", {16'd0, gap_count}, 0);
    force_empty = 1'b0;
    push_word(3'd1, 5'($urandom_range(0, 31)), 1'b0);
    drain("t5");
    check("t5_word_count", {16'd0, word_count}, 1);
    check("t5_gap_count", {16'd0, gap_count}, 0);
    check("t5_word_count_s", {28'd0, word_count_s}, 1);

    // Reset with a read in flight and a word buffered
    out_ready = 1'b0;
    base = rd_cnt;
    push_word(3'd4, 5'($urandom_range(0, 31)), 1'b1);
    push_word(3'd5, 5'($urandom_range(0, 31)), 1'b0);
    push_word(3'd6, 5'($urandom_range(0, 31)), 1'b0);
    repeat (6) step();
    check("t6_reads_held", rd_cnt - base, 2);
    check("t6_valid_held", {31'd0, out_valid}, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_reads_inflight", rd_cnt - base, 3);
    check("t6_rst_valid", {31'd0, out_valid}, 0);
    check("t6_rst_rd_en", {31'd0, fifo_rd_en}, 0);
    check("t6_rst_out", {23'd0, out_seq_err, out_start_count, out_phase_tag}, 0);
    check("t6_rst_counts", {word_count, gap_count}, 0);
    exp_q.delete();
    step(); step();
    rst = 1'b0;
    out_ready = 1'b1;
    push_word(3'd3, 5'($urandom_range(0, 31)), 1'b0);
    drain("t6");
    check("t6_word_count", {16'd0, word_count}, 1);
    check("t6_gap_count", {16'd0, gap_count}, 0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++)
      push_word(3'((4 + i) % 8), 5'($urandom_range(0, 31)), 1'b0);
    drain("t7");
    check("t7_word_count", {16'd0, word_count}, 21);
    check("t7_gap_count", {16'd0, gap_count}, 0);
    check("t7_word_count_sat", {28'd0, word_count_s}, 15);
    check("t7_gap_count_s", {28'd0, gap_count_s}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
